// File: rtl/line_point_reader_if.sv
// Point-buffer read port plus the valid/ready point stream towards the plotter.
interface line_point_reader_if;
  logic [31:0] index_rd;
  logic [31:0] line_x;
  logic [31:0] line_y;
  logic [31:0] out_x;
  logic [31:0] out_y;
  logic [31:0] out_idx;
  logic        out_clip;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output index_rd, out_x, out_y, out_idx, out_clip, out_valid,
    input  line_x, line_y, out_ready
  );

  modport slave (
    input  index_rd, out_x, out_y, out_idx, out_clip, out_valid,
    output line_x, line_y, out_ready
  );
endinterface

// File: rtl/line_point_reader.sv
// Walks point-buffer indices 0..n-1 after the writer finishes, tags off-screen
// points and streams every (x, y) pair to the plotter.
module line_point_reader #(
  parameter int DEPTH  = 31,
  parameter int RD_LAT = 1,
  parameter int X_MAX  = 639,
  parameter int Y_MAX  = 479
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [31:0]          range,
  input  logic                 src_finish,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           state_dbg,
  line_point_reader_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_SRC = 3'd1,
    S_ADDR     = 3'd2,
    S_LAT      = 3'd3,
    S_OUT      = 3'd4,
    S_FIN      = 3'd5
  } state_t;

  localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
  localparam logic [31:0] X_MAX_W  = 32'(X_MAX);
  localparam logic [31:0] Y_MAX_W  = 32'(Y_MAX);
  localparam logic [2:0]  LAT_INIT = 3'(RD_LAT - 1);

  state_t      state;
  logic [31:0] n;
  logic [31:0] idx;
  logic [2:0]  lat_cnt;
  logic        clip_now;

  assign state_dbg = state;

  // Negative values have bit 31 set, so the unsigned bound checks cover them
  // too; the explicit sign terms keep the intent readable.
  assign clip_now = bus.line_x[31] | bus.line_y[31] |
                    (bus.line_x > X_MAX_W) | (bus.line_y > Y_MAX_W);

  // Stream handshake: a point transfers on a rising edge where out_valid and
  // out_ready are both high; out_valid is a pure register (never a function of
  // out_ready), and once raised it and the payload stay frozen until transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      n             <= '0;
      idx           <= '0;
      lat_cnt       <= '0;
      bus.index_rd  <= '0;
      bus.out_x     <= '0;
      bus.out_y     <= '0;
      bus.out_idx   <= '0;
      bus.out_clip  <= 1'b0;
      bus.out_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            n     <= (range > DEPTH_W) ? DEPTH_W : range;
            busy  <= 1'b1;
            state <= S_WAIT_SRC;
          end
        end
        S_WAIT_SRC: begin
          if (src_finish) begin
            idx <= '0;
            if (n == '0) begin
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              // index_rd is registered, so it is loaded on the way into ADDR
              bus.index_rd <= '0;
              state        <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          lat_cnt <= LAT_INIT;
          state   <= S_LAT;
        end
        S_LAT: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 3'd1;
          end else begin
            bus.out_x     <= bus.line_x;
            bus.out_y     <= bus.line_y;
            bus.out_idx   <= idx;
            bus.out_clip  <= clip_now;
            bus.out_valid <= 1'b1;
            state         <= S_OUT;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (idx == n - 32'd1) begin
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              idx          <= idx + 32'd1;
              bus.index_rd <= idx + 32'd1;
              state        <= S_ADDR;
            end
          end
        end
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_point_reader.sv
// Directed bench for line_point_reader: buffer model, expected-point queue,
// and immediate-assertion checks.
module tb_line_point_reader;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_ADDR = 3'd2;
  localparam logic [2:0] ST_LAT  = 3'd3;
  localparam logic [2:0] ST_OUT  = 3'd4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        src_finish = 1'b0;
  logic [31:0] range = '0;
  logic        busy;
  logic        done;
  logic [2:0]  state_dbg;

  line_point_reader_if bus ();

  line_point_reader #(
    .DEPTH (31),
    .RD_LAT(1),
    .X_MAX (639),
    .Y_MAX (479)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .range     (range),
    .src_finish(src_finish),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // point buffer model, one cycle read latency
  logic [31:0] x_mem [0:31];
  logic [31:0] y_mem [0:31];
  always @(posedge clk) begin
    bus.line_x <= x_mem[bus.index_rd[4:0]];
    bus.line_y <= y_mem[bus.index_rd[4:0]];
  end

  // ---------------- scoreboard ----------------
  logic [96:0] exp_q[$];
  int n_checks = 0;
  int n_fails  = 0;
  int xfer_cnt = 0;
  int valid_cnt = 0;
  int cyc = 0;
  int last_hs_cyc = -10;
  logic        hold_pend = 1'b0;
  logic [96:0] held = '0;
  logic [96:0] cur;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [96:0] obs, input logic [96:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [96:0] pt(input logic clip, input logic [31:0] idx,
                                     input logic [31:0] x, input logic [31:0] y);
    return {clip, idx, x, y};
  endfunction

  assign cur = {bus.out_clip, bus.out_idx, bus.out_x, bus.out_y};

  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (bus.out_valid) valid_cnt++;
      if (hold_pend) begin
        check("valid_hold", {96'd0, bus.out_valid}, 97'd1);
        check("data_hold", cur, held);
      end
      if (bus.out_valid && bus.out_ready) begin
        xfer_cnt++;
        last_hs_cyc = cyc;
        check("xfer_expected", {96'd0, exp_q.size() != 0}, 97'd1);
        if (exp_q.size() != 0) check("xfer_data", cur, exp_q.pop_front());
      end
      hold_pend = bus.out_valid && !bus.out_ready;
      held      = cur;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pass(input logic [31:0] r);
    start = 1'b1;
    range = r;
    tick();
    start = 1'b0;
    range = 32'd0;
  endtask

  task automatic wait_done(input int limit, output int ticks);
    ticks = 0;
    while (!done && ticks < limit) begin
      tick();
      ticks++;
    end
    check("done_seen", {96'd0, done}, 97'd1);
  endtask

  task automatic push_pattern(input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back(pt(1'b0, 32'(i), 32'(10 + i), 32'(2 * (10 + i) + 3)));
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < 32; i++) begin
      x_mem[i] = 32'(10 + i);
      y_mem[i] = 32'(2 * (10 + i) + 3);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_index_rd"}, bus.index_rd, 0);
    check({tag, "_out_x"}, bus.out_x, 0);
    check({tag, "_out_y"}, bus.out_y, 0);
    check({tag, "_out_idx"}, bus.out_idx, 0);
    check({tag, "_out_clip"}, bus.out_clip, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_state"}, state_dbg, ST_IDLE);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int ticks;
    int x0;
    int v0;
    bus.out_ready = 1'b0;
    fill_pattern();

    // reset
    rst = 1'b1;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;

    // basic readout, full throughput
    src_finish    = 1'b1;
    bus.out_ready = 1'b1;
    push_pattern(5);
    x0 = xfer_cnt;
    start_pass(32'd5);
    check("basic_wait_state", state_dbg, ST_WAIT);
    check("basic_busy", busy, 1);
    tick();
    check("basic_addr_state", state_dbg, ST_ADDR);
    check("basic_index0", bus.index_rd, 0);
    wait_done(100, ticks);
    check("basic_cycles", ticks, 15);
    check("basic_xfers", xfer_cnt - x0, 5);
    check("basic_queue_empty", exp_q.size(), 0);
    check("basic_done_after_last", cyc - last_hs_cyc, 1);
    tick();
    check("basic_done_low", done, 0);
    check("basic_busy_low", busy, 0);
    check("basic_idle", state_dbg, ST_IDLE);

    // backpressure: three stalled cycles per point
    bus.out_ready = 1'b0;
    push_pattern(5);
    x0 = xfer_cnt;
    start_pass(32'd5);
    for (int p = 0; p < 5; p++) begin
      ticks = 0;
      while (!bus.out_valid && ticks < 20) begin
        tick();
        ticks++;
      end
      check("bp_valid_seen", bus.out_valid, 1);
      repeat (3) tick();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
    wait_done(10, ticks);
    check("bp_xfers", xfer_cnt - x0, 5);
    check("bp_queue_empty", exp_q.size(), 0);
    tick();

    // clip boundaries
    x_mem[0] = 32'hFFFF_FFFF; y_mem[0] = 32'd5;
    x_mem[1] = 32'd640;       y_mem[1] = 32'd0;
    x_mem[2] = 32'd639;       y_mem[2] = 32'd479;
    x_mem[3] = 32'd0;         y_mem[3] = 32'd480;
    exp_q.push_back(pt(1'b1, 32'd0, 32'hFFFF_FFFF, 32'd5));
    exp_q.push_back(pt(1'b1, 32'd1, 32'd640, 32'd0));
    exp_q.push_back(pt(1'b0, 32'd2, 32'd639, 32'd479));
    exp_q.push_back(pt(1'b1, 32'd3, 32'd0, 32'd480));
    bus.out_ready = 1'b1;
    x0 = xfer_cnt;
    start_pass(32'd4);
    wait_done(100, ticks);
    check("clip_xfers", xfer_cnt - x0, 4);
    check("clip_queue_empty", exp_q.size(), 0);
    tick();
    fill_pattern();

    // range = 0
    x0 = xfer_cnt;
    v0 = valid_cnt;
    start_pass(32'd0);
    wait_done(20, ticks);
    check("zero_ticks", ticks, 1);
    check("zero_no_valid", valid_cnt - v0, 0);
    check("zero_no_xfer", xfer_cnt - x0, 0);
    tick();
    check("zero_idle", state_dbg, ST_IDLE);

    // range clamps to DEPTH
    push_pattern(31);
    x0 = xfer_cnt;
    start_pass(32'd100);
    wait_done(300, ticks);
    check("clamp_ticks", ticks, 94);
    check("clamp_xfers", xfer_cnt - x0, 31);
    check("clamp_queue_empty", exp_q.size(), 0);
    check("clamp_last_index", bus.index_rd, 30);
    tick();

    // gating on src_finish, start ignored mid-pass
    src_finish = 1'b0;
    push_pattern(3);
    x0 = xfer_cnt;
    start_pass(32'd3);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("gate_index_hold", bus.index_rd, 30);
      check("gate_no_valid", bus.out_valid, 0);
      check("gate_wait_state", state_dbg, ST_WAIT);
    end
    src_finish = 1'b1;
    tick();
    check("gate_addr", state_dbg, ST_ADDR);
    check("gate_index0", bus.index_rd, 0);
    check("gate_addr_no_valid", bus.out_valid, 0);
    src_finish = 1'b0;
    start = 1'b1;
    range = 32'd7;
    tick();
    start = 1'b0;
    range = 32'd0;
    check("gate_lat", state_dbg, ST_LAT);
    check("gate_lat_no_valid", bus.out_valid, 0);
    tick();
    check("gate_out_valid", bus.out_valid, 1);
    wait_done(50, ticks);
    check("gate_xfers", xfer_cnt - x0, 3);
    check("gate_queue_empty", exp_q.size(), 0);
    tick();
    check("gate_busy_low", busy, 0);
    tick();
    check("gate_no_restart", state_dbg, ST_IDLE);

    // reset while point 2 is waiting in OUT
    src_finish = 1'b1;
    push_pattern(2);
    x0 = xfer_cnt;
    start_pass(32'd5);
    ticks = 0;
    while (!(bus.out_valid && bus.out_idx == 32'd2) && ticks < 50) begin
      tick();
      ticks++;
    end
    bus.out_ready = 1'b0;
    check("mid_out_state", state_dbg, ST_OUT);
    check("mid_out_idx", bus.out_idx, 2);
    rst = 1'b1;
    tick();
    check_reset_outputs("midreset");
    rst = 1'b0;
    check("mid_xfers", xfer_cnt - x0, 2);
    check("mid_queue_empty", exp_q.size(), 0);
    tick();
    check("mid_no_done", done, 0);
    check("mid_idle", state_dbg, ST_IDLE);

    // restart begins at index 0
    push_pattern(2);
    bus.out_ready = 1'b1;
    x0 = xfer_cnt;
    start_pass(32'd2);
    tick();
    check("restart_addr", state_dbg, ST_ADDR);
    check("restart_index0", bus.index_rd, 0);
    wait_done(50, ticks);
    check("restart_xfers", xfer_cnt - x0, 2);
    check("restart_queue_empty", exp_q.size(), 0);
    tick();
    check("restart_idle", state_dbg, ST_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
